// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the chunked serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int calc_nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int calc_cnt_w(input int width, input int chunk);
    int n;
    n = width / chunk;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_subtractor_chunk_subtractor.sv
// Combinational CHUNK-bit subtractor built as a ripple of full-subtractor cells.
module chunk_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bin,
  output logic [CHUNK-1:0] d,
  output logic             bout
);

  logic [CHUNK:0] borrow;

  assign borrow[0] = bin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_cell
    assign d[i]          = a[i] ^ b[i] ^ borrow[i];
    assign borrow[i+1]   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow[i]);
  end

  assign bout = borrow[CHUNK];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle a - b, CHUNK bits per clock, with optional |a - b| and swap flag.
//  state | meaning
//  IDLE  | waiting for operands, in_ready = 1
//  SUB   | one chunk per cycle, LSB chunk first
//  FIX   | negate result when abs_mode and a < b
//  DONE  | result presented, out_valid = 1
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abs_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             swap
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int CNT_W  = calc_cnt_w(WIDTH, CHUNK);

  if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("serial_subtractor: illegal WIDTH/CHUNK combination");
  end

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             abs_q;
  logic             borrow_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             swap_q;

  logic [CHUNK-1:0] d_chunk;
  logic             borrow_next;
  logic             last_chunk;

  chunk_subtractor #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_q[CHUNK-1:0]),
    .b    (b_q[CHUNK-1:0]),
    .bin  (borrow_q),
    .d    (d_chunk),
    .bout (borrow_next)
  );

  assign last_chunk = (cnt_q == CNT_W'(NCHUNK - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      abs_q    <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      swap_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            abs_q    <= abs_mode;
            borrow_q <= 1'b0;
            cnt_q    <= '0;
            state    <= SUB;
          end
        end
        SUB: begin
          a_q      <= a_q >> CHUNK;
          b_q      <= b_q >> CHUNK;
          // new chunk enters at the top so the LSB chunk ends up at bit 0
          diff_q   <= (diff_q >> CHUNK) | (WIDTH'(d_chunk) << (WIDTH - CHUNK));
          borrow_q <= borrow_next;
          cnt_q    <= cnt_q + 1'b1;
          if (last_chunk) begin
            bout_q <= borrow_next;
            swap_q <= abs_q & borrow_next;
            state  <= (abs_q & borrow_next) ? FIX : DONE;
          end
        end
        FIX: begin
          diff_q <= (~diff_q) + 1'b1;
          state  <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign swap      = swap_q;

endmodule
